// File: rtl/io_device_regfile.sv
// Memory-mapped I/O slave: NUM_LINES writable bus-wide lines. Reads are answered through an
// in-order response FIFO that mc_avail_o paces, and a sticky overflow flag records dropped reads.
module io_device_regfile #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned BUS_WIDTH     = 512,
    parameter int unsigned NUM_LINES     = 4,
    parameter int unsigned RESP_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] n2m_request_address,
    input  logic [BUS_WIDTH-1:0]     n2m_request_data,
    input  logic                     n2m_request_read,
    input  logic                     n2m_request_write,
    input  logic                     mc_avail_o,
    output logic                     m2n_request_available,
    output logic                     m2n_response_valid,
    output logic [ADDRESS_WIDTH-1:0] m2n_response_address,
    output logic [BUS_WIDTH-1:0]     m2n_response_data,
    output logic                     overflow_o
);

    localparam int unsigned OFF   = $clog2(BUS_WIDTH / 8);
    localparam int unsigned IW    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int unsigned WORDS = BUS_WIDTH / 32;
    localparam int unsigned PW    = $clog2(RESP_DEPTH);
    localparam int unsigned CW    = $clog2(RESP_DEPTH + 1);
    localparam int unsigned EW    = ADDRESS_WIDTH + BUS_WIDTH;

    function automatic logic [BUS_WIDTH-1:0] reset_line(input int unsigned i);
        logic [BUS_WIDTH-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < WORDS; j++) begin
            r[j*32 +: 32] = {i[15:0], j[15:0]};
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Line decode: higher address bits above the index are deliberately ignored.
    logic [IW-1:0]        idx;
    logic                 in_range;
    logic [BUS_WIDTH-1:0] rd_line;

    assign idx      = IW'(n2m_request_address >> OFF);
    assign in_range = 32'(idx) < NUM_LINES;

    logic [BUS_WIDTH-1:0] line_q [NUM_LINES];

    assign rd_line = in_range ? line_q[idx] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                line_q[i] <= reset_line(i);
            end
        end else if (n2m_request_write && in_range) begin
            line_q[idx] <= n2m_request_data;
        end
    end

    logic [EW-1:0] fifo_mem [RESP_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full                  = (count_q == CW'(RESP_DEPTH));
    assign empty                 = (count_q == '0);
    assign push                  = n2m_request_read && !full;
    assign pop                   = !empty && mc_avail_o;
    assign m2n_request_available = !full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {n2m_request_address, rd_line};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q             <= '0;
            rd_ptr_q             <= '0;
            count_q              <= '0;
            m2n_response_valid   <= 1'b0;
            m2n_response_address <= '0;
            m2n_response_data    <= '0;
            overflow_o           <= 1'b0;
        end else begin
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
            m2n_response_valid <= pop;
            if (pop) begin
                {m2n_response_address, m2n_response_data} <= fifo_mem[rd_ptr_q];
            end
            if (n2m_request_read && full) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_device_regfile.sv
// Directed bench for io_device_regfile: a 4-line instance and a 3-line instance for
// out-of-range decoding.
module tb_io_device_regfile;

    logic         clk;
    logic         reset;
    logic [31:0]  addr, addr3;
    logic [511:0] wdata, wdata3;
    logic         rd, wr, avail, rd3, wr3, avail3;
    logic         req_avail, rsp_valid, ovf;
    logic [31:0]  rsp_addr;
    logic [511:0] rsp_data;
    logic         req_avail3, rsp_valid3, ovf3;
    logic [31:0]  rsp_addr3;
    logic [511:0] rsp_data3;

    int tests_run;
    int tests_failed;

    localparam logic [511:0] ALL_A5 = {64{8'hA5}};
    localparam logic [511:0] ALL_5A = {64{8'h5A}};

    io_device_regfile #(.NUM_LINES(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .n2m_request_address   (addr),
        .n2m_request_data      (wdata),
        .n2m_request_read      (rd),
        .n2m_request_write     (wr),
        .mc_avail_o            (avail),
        .m2n_request_available (req_avail),
        .m2n_response_valid    (rsp_valid),
        .m2n_response_address  (rsp_addr),
        .m2n_response_data     (rsp_data),
        .overflow_o            (ovf)
    );

    io_device_regfile #(.NUM_LINES(3)) dut3 (
        .clk                   (clk),
        .reset                 (reset),
        .n2m_request_address   (addr3),
        .n2m_request_data      (wdata3),
        .n2m_request_read      (rd3),
        .n2m_request_write     (wr3),
        .mc_avail_o            (avail3),
        .m2n_request_available (req_avail3),
        .m2n_response_valid    (rsp_valid3),
        .m2n_response_address  (rsp_addr3),
        .m2n_response_data     (rsp_data3),
        .overflow_o            (ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] exp_line(input int unsigned i);
        logic [511:0] r;
        for (int unsigned j = 0; j < 16; j++) begin
            r[j*32 +: 32] = {i[15:0], j[15:0]};
        end
        return r;
    endfunction

    // Contents of the main instance after test_write_read has run.
    function automatic logic [511:0] exp_content(input int unsigned i);
        case (i)
            2:       return ALL_A5;
            3:       return ALL_5A;
            default: return exp_line(i);
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3 reset = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid got %b want 0", rsp_valid);
        end
        tests_run++;
        if (rsp_addr !== 32'h0 || rsp_data !== 512'h0) begin
            tests_failed++; $display("FAIL reset_addr_data got %h/%h want 0", rsp_addr, rsp_data);
        end
        tests_run++;
        if (ovf !== 1'b0 || req_avail !== 1'b1) begin
            tests_failed++; $display("FAIL reset_flags got ovf=%b avail=%b want 0/1", ovf, req_avail);
        end
        tick;
        tick;
        reset = 1'b1;
    endtask

    task automatic test_read_basic;
        addr = 32'h40; rd = 1'b1;
        tick;
        rd = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL early_valid got %b want 0", rsp_valid);
        end
        tick;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_addr !== 32'h40) begin
            tests_failed++; $display("FAIL basic_rsp got v=%b a=%h want 1/40", rsp_valid, rsp_addr);
        end
        tests_run++;
        if (rsp_data[31:0] !== 32'h0001_0000 || rsp_data[511:480] !== 32'h0001_000F) begin
            tests_failed++;
            $display("FAIL basic_words got %h/%h want 00010000/0001000f",
                     rsp_data[31:0], rsp_data[511:480]);
        end
        tick;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL single_beat got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_write_read;
        addr = 32'h80; wdata = ALL_A5; wr = 1'b1;
        tick;
        wr = 1'b0; rd = 1'b1;
        tick;
        rd = 1'b0;
        tick;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== ALL_A5) begin
            tests_failed++; $display("FAIL write_then_read got v=%b d=%h want a5s", rsp_valid, rsp_data);
        end
        addr = 32'hC0; wdata = ALL_5A; wr = 1'b1; rd = 1'b1;
        tick;
        wr = 1'b0; rd = 1'b0;
        tick;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_line(3)) begin
            tests_failed++; $display("FAIL same_cycle_old got v=%b d=%h want %h", rsp_valid, rsp_data, exp_line(3));
        end
        rd = 1'b1;
        tick;
        rd = 1'b0;
        tick;
        tests_run++;
        if (rsp_data !== ALL_5A) begin
            tests_failed++; $display("FAIL same_cycle_write got %h want 5as", rsp_data);
        end
        tick;
    endtask

    task automatic test_overflow;
        avail = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (req_avail !== 1'b1) begin
                tests_failed++; $display("FAIL avail_before_full k=%0d got %b want 1", k, req_avail);
            end
            addr = 32'(k * 64); rd = 1'b1;
            tick;
        end
        tests_run++;
        if (req_avail !== 1'b0) begin
            tests_failed++; $display("FAIL avail_when_full got %b want 0", req_avail);
        end
        addr = 32'h100;
        tick;
        rd = 1'b0;
        tests_run++;
        if (ovf !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL overflow_set got ovf=%b v=%b want 1/0", ovf, rsp_valid);
        end
        avail = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_addr !== 32'(k * 64) || rsp_data !== exp_content(k)) begin
                tests_failed++;
                $display("FAIL drain_order k=%0d got v=%b a=%h want 1/%h", k, rsp_valid, rsp_addr, k * 64);
            end
            if (k == 0) begin
                tests_run++;
                if (req_avail !== 1'b1) begin
                    tests_failed++; $display("FAIL avail_after_pop got %b want 1", req_avail);
                end
            end
        end
        tick;
        tests_run++;
        if (rsp_valid !== 1'b0 || ovf !== 1'b1) begin
            tests_failed++; $display("FAIL extra_rsp_or_ovf got v=%b ovf=%b want 0/1", rsp_valid, ovf);
        end
    endtask

    task automatic test_out_of_range;
        addr3 = 32'hC0; rd3 = 1'b1;
        tick;
        rd3 = 1'b0;
        tick;
        tests_run++;
        if (rsp_valid3 !== 1'b1 || rsp_addr3 !== 32'hC0 || rsp_data3 !== 512'h0) begin
            tests_failed++;
            $display("FAIL oor_read got v=%b a=%h d=%h want 1/c0/0", rsp_valid3, rsp_addr3, rsp_data3);
        end
        wdata3 = '1; wr3 = 1'b1;
        tick;
        wr3 = 1'b0; addr3 = 32'h0; rd3 = 1'b1;
        tick;
        rd3 = 1'b0;
        tick;
        tests_run++;
        if (rsp_data3 !== exp_line(0)) begin
            tests_failed++; $display("FAIL oor_write got %h want %h", rsp_data3, exp_line(0));
        end
        addr3 = 32'h100; rd3 = 1'b1;
        tick;
        rd3 = 1'b0;
        tick;
        tests_run++;
        if (rsp_addr3 !== 32'h100 || rsp_data3 !== exp_line(0)) begin
            tests_failed++; $display("FAIL alias_read got a=%h d=%h want 100/%h", rsp_addr3, rsp_data3, exp_line(0));
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [12];
        for (int k = 0; k < 12; k++) begin
            a[k] = (32'(k) << 8) | (32'(k % 4) << 6);
        end
        avail = 1'b0; rd = 1'b1;
        addr = a[0];
        tick;
        addr = a[1];
        tick;
        avail = 1'b1;
        for (int k = 2; k < 12; k++) begin
            addr = a[k];
            tick;
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_addr !== a[k-2] || rsp_data !== exp_content((k - 2) % 4)
                || req_avail !== 1'b1) begin
                tests_failed++;
                $display("FAIL wrap k=%0d got v=%b a=%h av=%b want 1/%h/1", k, rsp_valid, rsp_addr, req_avail, a[k-2]);
            end
        end
        rd = 1'b0;
        for (int k = 10; k < 12; k++) begin
            tick;
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_addr !== a[k]) begin
                tests_failed++; $display("FAIL wrap_drain k=%0d got v=%b a=%h want 1/%h", k, rsp_valid, rsp_addr, a[k]);
            end
        end
        tick;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL wrap_count got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid;
        avail = 1'b0; rd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr = 32'(k * 64);
            tick;
        end
        rd = 1'b1; addr = 32'h0;
        tick;
        rd = 1'b0; avail = 1'b1;
        tick;
        avail = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || ovf !== 1'b1) begin
            tests_failed++; $display("FAIL pre_reset got v=%b ovf=%b want 1/1", rsp_valid, ovf);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || ovf !== 1'b0 || req_avail !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset got v=%b ovf=%b av=%b want 0/0/1", rsp_valid, ovf, req_avail);
        end
        tests_run++;
        if (rsp_addr !== 32'h0 || rsp_data !== 512'h0) begin
            tests_failed++; $display("FAIL async_reset_regs got %h/%h want 0", rsp_addr, rsp_data);
        end
        tick;
        reset = 1'b1; avail = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            tests_run++;
            if (rsp_valid !== 1'b0) begin
                tests_failed++; $display("FAIL stale_rsp k=%0d got %b want 0", k, rsp_valid);
            end
        end
        addr = 32'h80; rd = 1'b1;
        tick;
        addr = 32'hC0;
        tick;
        rd = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_line(2)) begin
            tests_failed++; $display("FAIL line2_reset got v=%b d=%h want %h", rsp_valid, rsp_data, exp_line(2));
        end
        tick;
        tests_run++;
        if (rsp_addr !== 32'hC0 || rsp_data !== exp_line(3)) begin
            tests_failed++; $display("FAIL line3_reset got a=%h d=%h want c0/%h", rsp_addr, rsp_data, exp_line(3));
        end
        tick;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        addr = '0; wdata = '0; rd = 1'b0; wr = 1'b0; avail = 1'b1;
        addr3 = '0; wdata3 = '0; rd3 = 1'b0; wr3 = 1'b0; avail3 = 1'b1;
        test_reset;
        test_read_basic;
        test_write_read;
        test_overflow;
        test_out_of_range;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/io_device_regfile.md
# io_device_regfile

Parametrised memory-mapped I/O slave on the NPU system bus, replacing the fixed-pattern single-response device. It holds NUM_LINES writable bus-wide lines and serves reads through a RESP_DEPTH-entry response FIFO. Reads are paced by mc_avail_o back-pressure. A sticky overflow flag records protocol violations. It sits on the same n2m/m2n interface as the memory controller and is selected by the system-bus address decoder.

## Interface
- ADDRESS_WIDTH, 32: request/response address width
- BUS_WIDTH, 512: line width in bits; a multiple of 32, minimum 32
- NUM_LINES, 4: number of storage lines; ≥1, need not be a power of two
- RESP_DEPTH, 4: response FIFO entries; ≥2
- clk, input, 1: single clock, rising edge
- reset, input, 1: asynchronous, active-low reset
- n2m_request_address, input, ADDRESS_WIDTH: byte address of the request
- n2m_request_data, input, BUS_WIDTH: write data
- n2m_request_read, input, 1: read request strobe, one cycle per request
- n2m_request_write, input, 1: write request strobe, one cycle per request
- mc_avail_o, input, 1: the requester can accept a response this cycle
- m2n_request_available, output, 1: the device can accept a request this cycle
- m2n_response_valid, output, 1: response beat valid
- m2n_response_address, output, ADDRESS_WIDTH: address of the read being answered
- m2n_response_data, output, BUS_WIDTH: read data
- overflow_o, output, 1: sticky flag; set when a read is dropped

## Operation
- Line index: idx = n2m_request_address >> OFF, where OFF = log2(BUS_WIDTH/8), truncated to IW = max(1, clog2(NUM_LINES)) bits.
  - Higher address bits are ignored.
  - If idx ≥ NUM_LINES, the address is out of range.
- Reset value of line i, 32-bit word j: {16'(i), 16'(j)}.
- Write (n2m_request_write=1): line[idx] ← n2m_request_data at the clock edge. Out-of-range writes are ignored. Writes are always accepted, even when the FIFO is full.
- Read (n2m_request_read=1) with FIFO not full: push {n2m_request_address, line[idx]} using the pre-edge line contents. Out-of-range reads push all-zero data.
- Read with FIFO full: the read is dropped and overflow_o is set. overflow_o stays high until reset.
- Read and write in the same cycle:
  - Both are performed.
  - The read captures the old data.
  - The write lands at the same edge.
- m2n_request_available = !full, combinational from the FIFO count.
- Pop rule: at each edge where the FIFO is non-empty and mc_avail_o=1:
  - the head moves into the response registers and m2n_response_valid=1 for the next cycle;
  - otherwise m2n_response_valid=0 next cycle, and the address/data registers hold their values.
- Push and pop in the same cycle: both occur and the count is unchanged. This is allowed when full: a pop frees the slot, but the push is still dropped because available was low.
- FIFO: circular buffer with wrapping read/write pointers and a count of width clog2(RESP_DEPTH+1). Responses leave in request order.

## Timing
- Reset values: m2n_response_valid=0, m2n_response_address=0, m2n_response_data=0, overflow_o=0, FIFO empty, m2n_request_available=1, lines at their reset pattern.
- Read latency: request in cycle N, response valid in cycle N+2 at the earliest (push at the end of N, pop at the end of N+1).
- Throughput: one response per cycle while mc_avail_o=1 and the FIFO is non-empty.
- Every response is a single-cycle valid beat. There is no hold or retry: the requester signals readiness through mc_avail_o before the pop edge.
- Reset asserted mid-operation: the FIFO is flushed, queued responses are lost, and the outputs and lines return to their reset values immediately (asynchronously).

## Test plan
- Reset, then read address 0x40 with mc_avail_o=1 → valid in cycle N+2, response_address=0x40, word0=0x00010000, word15=0x0001000F.
- Write line 2 with all-0xA5, then read line 2 the next cycle → data all-0xA5. Read and write of line 3 in the same cycle → the read returns the reset pattern {3, j}.
- mc_avail_o=0, issue 4 reads → m2n_request_available drops after the 4th. A 5th read → overflow_o=1. Then raise mc_avail_o → exactly 4 responses in order, back-to-back.
- NUM_LINES=3, read of idx 3 → data 0; write to idx 3 → line 0 is unchanged.
- Keep the FIFO at 2 entries with a push and a pop every cycle for 10 cycles → the pointers wrap and the response order and count are correct.
- Assert reset with 3 entries queued → valid=0, FIFO empty, overflow_o=0, lines back to their reset pattern. After release, no stale response appears.
